// File: rtl/turn_signal_decoder.sv
// Receive-side observer for the tail-light lamp bus: classifies lamp steps into
// idle/left/right/hazard modes, flags illegal or stuck patterns, counts sweeps.
module turn_signal_decoder #(
    parameter int TIMEOUT    = 10_000_000,
    parameter int LOCK_COUNT = 2
) (
    input  logic       ADC_CLK_10,
    input  logic       KEY0,
    input  logic [2:0] LAMP_L,
    input  logic [2:0] LAMP_R,
    output logic [1:0] MODE,
    output logic       FAULT,
    output logic [7:0] SEQ_COUNT,
    output logic [7:0] HEX0
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEFT, S_RIGHT, S_HAZARD, S_FAULT} state_t;
    typedef enum logic [1:0] {C_NONE, C_LEFT, C_RIGHT, C_HAZ} cls_t;

    logic [5:0]    lamp_q, lamp_prev;
    logic [TW-1:0] timer;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    seq, seq_nxt;
    state_t        state, state_nxt;
    cls_t          cand, cand_nxt, step;
    logic          change, timeout_fire;

    // Successor in the outward sweep; unknown codes map to themselves so they never match.
    function automatic logic [2:0] sweep_next(input logic [2:0] x);
        case (x)
            3'b000:  return 3'b001;
            3'b001:  return 3'b011;
            3'b011:  return 3'b111;
            3'b111:  return 3'b000;
            default: return x;
        endcase
    endfunction

    function automatic state_t state_of(input cls_t c);
        case (c)
            C_LEFT:  return S_LEFT;
            C_RIGHT: return S_RIGHT;
            C_HAZ:   return S_HAZARD;
            default: return S_IDLE;
        endcase
    endfunction

    function automatic cls_t cls_of(input state_t s);
        case (s)
            S_LEFT:   return C_LEFT;
            S_RIGHT:  return C_RIGHT;
            S_HAZARD: return C_HAZ;
            default:  return C_NONE;
        endcase
    endfunction

    function automatic logic [7:0] hex_of(input state_t s);
        case (s)
            S_LEFT:   return 8'hC7;
            S_RIGHT:  return 8'hAF;
            S_HAZARD: return 8'h89;
            S_FAULT:  return 8'h8E;
            default:  return 8'hBF;
        endcase
    endfunction

    assign change       = (lamp_q != lamp_prev);
    assign timeout_fire = !change && (timer == TMAX);
    assign SEQ_COUNT    = seq;

    always_comb begin
        step = C_NONE;
        if (lamp_prev[2:0] == 3'b000 && lamp_q[2:0] == 3'b000 &&
            lamp_q[5:3] == sweep_next(lamp_prev[5:3]))
            step = C_LEFT;
        else if (lamp_prev[5:3] == 3'b000 && lamp_q[5:3] == 3'b000 &&
                 lamp_q[2:0] == sweep_next(lamp_prev[2:0]))
            step = C_RIGHT;
        else if ((lamp_prev == 6'h00 && lamp_q == 6'h3F) ||
                 (lamp_prev == 6'h3F && lamp_q == 6'h00))
            step = C_HAZ;
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        seq_nxt   = seq;
        if (change) begin
            unique case (state)
                S_IDLE: begin
                    if (step == C_NONE) begin
                        cnt_nxt = '0;
                    end else begin
                        if (step == cand) begin
                            cnt_nxt = cnt + CW'(1);
                        end else begin
                            cand_nxt = step;
                            cnt_nxt  = CW'(1);
                        end
                        if (cnt_nxt >= CW'(LOCK_COUNT)) begin
                            state_nxt = state_of(step);
                            seq_nxt   = '0;
                            cand_nxt  = C_NONE;
                            cnt_nxt   = '0;
                        end
                    end
                end
                S_LEFT, S_RIGHT, S_HAZARD: begin
                    if (step == C_NONE) begin
                        state_nxt = S_FAULT;
                    end else if (step == cls_of(state)) begin
                        // A sweep completes when the same-class step lands on all-dark.
                        if (lamp_q == 6'h00 && seq != 8'hFF)
                            seq_nxt = seq + 8'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        cand_nxt  = step;
                        cnt_nxt   = CW'(1);
                    end
                end
                default: ;
            endcase
        end else if (timeout_fire) begin
            state_nxt = (lamp_q == 6'h00) ? S_IDLE : S_FAULT;
            cand_nxt  = C_NONE;
            cnt_nxt   = '0;
        end
        if (state_nxt == S_IDLE || state_nxt == S_FAULT)
            seq_nxt = '0;
    end

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            lamp_q    <= '0;
            lamp_prev <= '0;
            timer     <= '0;
            state     <= S_IDLE;
            cand      <= C_NONE;
            cnt       <= '0;
            seq       <= '0;
            MODE      <= 2'b00;
            FAULT     <= 1'b0;
            HEX0      <= 8'hBF;
        end else begin
            lamp_q    <= {LAMP_L, LAMP_R};
            lamp_prev <= lamp_q;
            // Saturating at TMAX keeps the timeout asserting for as long as the bus stays quiet.
            if (change)
                timer <= '0;
            else if (timer != TMAX)
                timer <= timer + TW'(1);
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            seq       <= seq_nxt;
            MODE      <= (state_nxt == S_FAULT) ? 2'b00 : 2'(cls_of(state_nxt));
            FAULT     <= (state_nxt == S_FAULT);
            HEX0      <= hex_of(state_nxt);
        end
    end

endmodule

// File: tb/tb_turn_signal_decoder.sv
// Bench for turn_signal_decoder: vector table, hand corner sequences and random
// lamp traffic, all checked against a cycle model built from the step rules.
module tb_turn_signal_decoder;
    localparam int TO = 8;
    localparam int LK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lamp_l, lamp_r;
    logic [1:0] mode;
    logic       fault;
    logic [7:0] seq_count, hex0;

    int checks = 0;
    int failures = 0;

    turn_signal_decoder #(.TIMEOUT(TO), .LOCK_COUNT(LK)) dut (
        .ADC_CLK_10(clk), .KEY0(rst_n), .LAMP_L(lamp_l), .LAMP_R(lamp_r),
        .MODE(mode), .FAULT(fault), .SEQ_COUNT(seq_count), .HEX0(hex0)
    );

    always #5 clk = ~clk;

    // Model state: st 0 idle, 1 left, 2 right, 3 hazard, 4 fault; cand 0 means none.
    typedef struct {
        int q, prev, quiet, st, cand, cnt, seq;
    } mstate_t;
    mstate_t m;

    function automatic int sweep_pos(input int v);
        int order[4] = '{0, 1, 3, 7};
        for (int i = 0; i < 4; i++) if (order[i] == v) return i;
        return -1;
    endfunction

    function automatic int step_class(input int p, input int n);
        int pl = p >> 3, pr = p & 7, nl = n >> 3, nr = n & 7;
        if (pr == 0 && nr == 0 && sweep_pos(pl) >= 0 && sweep_pos(nl) == (sweep_pos(pl) + 1) % 4) return 1;
        if (pl == 0 && nl == 0 && sweep_pos(pr) >= 0 && sweep_pos(nr) == (sweep_pos(pr) + 1) % 4) return 2;
        if ((p == 0 && n == 63) || (p == 63 && n == 0)) return 3;
        return 0;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input int lamps);
        mstate_t n = s;
        int c;
        if (s.q != s.prev) begin
            c = step_class(s.prev, s.q);
            n.quiet = 0;
            if (s.st == 0) begin
                if (c == 0) n.cnt = 0;
                else begin
                    if (c == s.cand) n.cnt = s.cnt + 1;
                    else begin n.cand = c; n.cnt = 1; end
                    if (n.cnt >= LK) begin n.st = c; n.seq = 0; n.cand = 0; n.cnt = 0; end
                end
            end else if (s.st != 4) begin
                if (c == 0) begin n.st = 4; n.seq = 0; end
                else if (c == s.st) begin
                    if (s.q == 0) n.seq = (s.seq < 255) ? s.seq + 1 : 255;
                end else begin n.st = 0; n.cand = c; n.cnt = 1; n.seq = 0; end
            end
        end else if (s.quiet == TO - 1) begin
            n.st = (s.q == 0) ? 0 : 4; n.cand = 0; n.cnt = 0; n.seq = 0;
        end else begin
            n.quiet = s.quiet + 1;
        end
        n.prev = s.q;
        n.q = lamps;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '{default: 0};
        else m <= model_step(m, int'({lamp_l, lamp_r}));

    function automatic logic [7:0] exp_hex(input int st);
        case (st)
            1: return 8'hC7;
            2: return 8'hAF;
            3: return 8'h89;
            4: return 8'h8E;
            default: return 8'hBF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check("model", {13'd0, mode, fault, seq_count, hex0},
                  {13'd0, 2'((m.st == 4) ? 0 : m.st), 1'(m.st == 4), 8'(m.seq), exp_hex(m.st)});
        end
    endtask

    task automatic apply(input logic [2:0] l, input logic [2:0] r, input int n);
        lamp_l = l;
        lamp_r = r;
        run(n);
    endtask

    task automatic expect_out(input string name, input logic [1:0] em, input logic ef,
                              input logic [7:0] es, input logic [7:0] eh);
        check({name, ".mode"}, 32'(mode), 32'(em));
        check({name, ".fault"}, 32'(fault), 32'(ef));
        check({name, ".seq"}, 32'(seq_count), 32'(es));
        check({name, ".hex"}, 32'(hex0), 32'(eh));
    endtask

    typedef struct {
        logic [2:0] l, r;
        int         hold;
        logic [1:0] mode;
        logic       fault;
        logic [7:0] seq, hex;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [2:0] l, input logic [2:0] r, input int hold, input logic [1:0] md,
                       input logic f, input logic [7:0] s, input logic [7:0] h);
        vec_t v;
        v.l = l; v.r = r; v.hold = hold; v.mode = md; v.fault = f; v.seq = s; v.hex = h;
        tbl.push_back(v);
    endtask

    function automatic logic [2:0] adv(input logic [2:0] x);
        case (x)
            3'b000: return 3'b001;
            3'b001: return 3'b011;
            3'b011: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        logic [2:0] cl, cr;
        int op;
        add(0, 0, 20, 0, 0, 0, 8'hBF);  // quiet bus stays idle
        add(1, 0, 4, 0, 0, 0, 8'hBF);
        add(3, 0, 4, 1, 0, 0, 8'hC7);   // lock left on second step
        add(7, 0, 4, 1, 0, 0, 8'hC7);
        add(0, 0, 4, 1, 0, 1, 8'hC7);
        add(7, 7, 4, 0, 0, 0, 8'hBF);   // hazard step drops back to idle
        add(0, 0, 4, 3, 0, 0, 8'h89);
        add(7, 7, 4, 3, 0, 0, 8'h89);
        add(0, 0, 4, 3, 0, 1, 8'h89);
        add(7, 7, 4, 3, 0, 1, 8'h89);
        add(0, 0, 4, 3, 0, 2, 8'h89);
        add(7, 7, 4, 3, 0, 2, 8'h89);
        add(0, 0, 4, 3, 0, 3, 8'h89);
        add(1, 0, 4, 0, 0, 0, 8'hBF);
        add(3, 0, 4, 1, 0, 0, 8'hC7);
        add(7, 0, 4, 1, 0, 0, 8'hC7);
        add(0, 0, 4, 1, 0, 1, 8'hC7);
        add(0, 1, 4, 0, 0, 0, 8'hBF);
        add(0, 3, 4, 2, 0, 0, 8'hAF);
        add(1, 3, 4, 0, 1, 0, 8'h8E);   // illegal jump
        add(0, 0, 4, 0, 1, 0, 8'h8E);   // change ignored in fault
        add(0, 0, 8, 0, 0, 0, 8'hBF);   // dark timeout exits fault
        add(1, 0, 4, 0, 0, 0, 8'hBF);
        add(3, 0, 4, 1, 0, 0, 8'hC7);
        add(7, 0, 9, 1, 0, 0, 8'hC7);   // one clock short of stuck timeout
        add(7, 0, 1, 0, 1, 0, 8'h8E);   // stuck lamp fires
        add(0, 0, 4, 0, 1, 0, 8'h8E);
        add(0, 0, 8, 0, 0, 0, 8'hBF);
        add(0, 0, 10, 0, 0, 0, 8'hBF);

        rst_n = 1'b0; lamp_l = 0; lamp_r = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_out("reset", 2'b00, 1'b0, 8'd0, 8'hBF);

        foreach (tbl[i]) begin
            apply(tbl[i].l, tbl[i].r, tbl[i].hold);
            expect_out($sformatf("vec%0d", i), tbl[i].mode, tbl[i].fault, tbl[i].seq, tbl[i].hex);
        end

        // Asynchronous reset in the middle of a right sweep with a nonzero count
        apply(0, 1, 4); apply(0, 3, 4); apply(0, 7, 4); apply(0, 0, 4);
        expect_out("pre_rst", 2'b10, 1'b0, 8'd1, 8'hAF);
        apply(0, 1, 2);
        #2 rst_n = 1'b0; lamp_l = 0; lamp_r = 0;
        #1 expect_out("async_rst", 2'b00, 1'b0, 8'd0, 8'hBF);
        run(2);
        rst_n = 1'b1;
        apply(0, 1, 4);
        expect_out("post_rst1", 2'b00, 1'b0, 8'd0, 8'hBF);
        apply(0, 3, 4);
        expect_out("post_rst2", 2'b10, 1'b0, 8'd0, 8'hAF);

        // Hazard toggling every clock until the sweep count saturates
        apply(0, 7, 2); apply(0, 0, 2);
        for (int i = 0; i < 520; i++) apply((i % 2 == 0) ? 3'd7 : 3'd0, (i % 2 == 0) ? 3'd7 : 3'd0, 1);
        run(2);
        expect_out("sat", 2'b11, 1'b0, 8'd255, 8'h89);
        apply(7, 7, 1); apply(0, 0, 2);
        expect_out("sat_hold", 2'b11, 1'b0, 8'd255, 8'h89);

        // Random traffic biased toward legal steps
        cl = 0; cr = 0;
        for (int i = 0; i < 800; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin cl = adv(cl); if ($urandom_range(0, 7) != 0) cr = 0; end
            else if (op <= 5) begin cr = adv(cr); if ($urandom_range(0, 7) != 0) cl = 0; end
            else if (op <= 7) begin
                if (cl == 0 && cr == 0) begin cl = 7; cr = 7; end else begin cl = 0; cr = 0; end
            end else if (op == 8) begin cl = 3'($urandom_range(0, 7)); cr = 3'($urandom_range(0, 7)); end
            apply(cl, cr, (op == 9) ? int'($urandom_range(8, 13)) : int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
